block_serial_tx: RTL and testbench

//  Source end of the two-wire link consumed by block's in1/in2 inputs.

---
 rtl/block_pkg.sv | 14 +
 rtl/block_tx_shift.sv | 42 ++++
 rtl/block_serial_tx.sv | 121 ++++++++++++
 tb/tb_block_serial_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// Shared definitions for the block serial link.
// State encoding and the parity rule used by both link ends.
package block_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;
  localparam logic [1:0] GAP_S = 2'd3;

  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/block_tx_shift.sv
// Load/shift register for one outgoing frame.
// Tracks bit position and captures parity at load time.
module block_tx_shift
  import block_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             bit_o,
  output logic             par,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
      par <= 1'b0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
      par <= even_par(64'(din));
    end else if (shift) begin
      sr  <= {sr[WIDTH-2:0], 1'b0};
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  assign bit_o = sr[WIDTH-1];
  assign last  = (cnt == CLAST);

endmodule

// File: rtl/block_serial_tx.sv
// Serial frame source for block: one-word buffer,
// MSB-first data plus even parity under a frame strobe.
module block_serial_tx
  import block_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             out1,
  output logic             out2,
  output logic             busy
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [GW-1:0]    gcnt;
  logic             load;
  logic             shift;
  logic             sh_bit;
  logic             sh_par;
  logic             sh_last;

  assign ready_out = ~hold_valid;
  assign busy      = (state != IDLE) | hold_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (valid_in && !hold_valid) begin
      hold       <= data_in;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        if (hold_valid) begin
          load     = 1'b1;
          state_nx = DATA;
        end
      end
      state == DATA: begin
        shift = 1'b1;
        if (sh_last) state_nx = PAR;
      end
      state == PAR: begin
        if (GAP > 0) begin
          state_nx = GAP_S;
        end else if (hold_valid) begin
          load     = 1'b1;
          state_nx = DATA;
        end else begin
          state_nx = IDLE;
        end
      end
      state == GAP_S: begin
        if (gcnt == GLAST) begin
          if (hold_valid) begin
            load     = 1'b1;
            state_nx = DATA;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == GAP_S && gcnt != GLAST) gcnt <= gcnt + GW'(1);
      else gcnt <= '0;
    end
  end

  block_tx_shift #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .rst_n (reset),
    .load  (load),
    .shift (shift),
    .din   (hold),
    .bit_o (sh_bit),
    .par   (sh_par),
    .last  (sh_last)
  );

  // outputs lag the FSM by one flop so the line is glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out1 <= 1'b0;
      out2 <= 1'b0;
    end else begin
      out2 <= (state == DATA) | (state == PAR);
      out1 <= (state == DATA) ? sh_bit :
              (state == PAR)  ? sh_par : 1'b0;
    end
  end

endmodule

// File: tb/tb_block_serial_tx.sv
// Bench for block_serial_tx: four parameterisations checked
// against a frame-level model of the serial stream.
module tb_block_serial_tx;

  logic       clk;
  logic       reset;
  logic [7:0] din   [4];
  logic       valid [4];
  logic       rdy   [4];
  logic       o1    [4];
  logic       o2    [4];
  logic       bsy   [4];

  int wd [4] = '{8, 8, 8, 2};

  bit ebits [4][$];
  bit obits [4][$];
  int rq    [4][$];
  int gq    [4][$];
  int rl [4];
  int zl [4];
  int seen [4];
  int viol [4];

  int total = 0;
  int bad   = 0;

  block_serial_tx #(.WIDTH(8), .GAP(1)) u0 (
    .clk(clk), .reset(reset), .data_in(din[0]), .valid_in(valid[0]),
    .ready_out(rdy[0]), .out1(o1[0]), .out2(o2[0]), .busy(bsy[0]));
  block_serial_tx #(.WIDTH(8), .GAP(0)) u1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .valid_in(valid[1]),
    .ready_out(rdy[1]), .out1(o1[1]), .out2(o2[1]), .busy(bsy[1]));
  block_serial_tx #(.WIDTH(8), .GAP(3)) u2 (
    .clk(clk), .reset(reset), .data_in(din[2]), .valid_in(valid[2]),
    .ready_out(rdy[2]), .out1(o1[2]), .out2(o2[2]), .busy(bsy[2]));
  block_serial_tx #(.WIDTH(2), .GAP(1)) u3 (
    .clk(clk), .reset(reset), .data_in(din[3][1:0]), .valid_in(valid[3]),
    .ready_out(rdy[3]), .out1(o1[3]), .out2(o2[3]), .busy(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (o1[i] === 1'bx) viol[i]++;
      if (o2[i]) begin
        obits[i].push_back(o1[i]);
        if (seen[i] != 0 && zl[i] > 0) gq[i].push_back(zl[i]);
        zl[i] = 0;
        rl[i]++;
        seen[i] = 1;
      end else begin
        if (rl[i] > 0) rq[i].push_back(rl[i]);
        rl[i] = 0;
        zl[i]++;
        if (o1[i] !== 1'b0) viol[i]++;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int i);
    obits[i].delete();
    ebits[i].delete();
    rq[i].delete();
    gq[i].delete();
    rl[i] = 0;
    zl[i] = 0;
    seen[i] = 0;
  endtask

  // expected frame: data MSB first, then even parity of the word
  task automatic send(input int i, input logic [7:0] w);
    int n = 0;
    logic p = 1'b0;
    din[i] = w;
    valid[i] = 1'b1;
    while (!rdy[i] && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("send_timeout", n, 0);
    step();
    valid[i] = 1'b0;
    din[i] = 'x;
    for (int b = wd[i] - 1; b >= 0; b--) begin
      ebits[i].push_back(w[b]);
      p = p ^ w[b];
    end
    ebits[i].push_back(p);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((bsy[i] || o2[i]) && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", int'(n < 300), 1);
    step();
    step();
  endtask

  task automatic chk_stream(input int i, input string tag);
    int ok = int'(obits[i].size() == ebits[i].size());
    if (ok != 0)
      foreach (ebits[i][k])
        if (obits[i][k] != ebits[i][k]) ok = 0;
    chk(tag, ok, 1);
  endtask

  int sum;
  logic [7:0] wa, wb;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[i] = 'x;
      valid[i] = 1'b0;
      clr(i);
      viol[i] = 0;
    end
    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk("rst_ready", rdy[i], 1);
      chk("rst_out1", o1[i], 0);
      chk("rst_out2", o2[i], 0);
      chk("rst_busy", bsy[i], 0);
    end
    #10 reset = 1'b1;
    step();

    // single word, latency and busy tail with one gap cycle
    clr(0);
    send(0, 8'hA5);
    chk("t1_rdy_full", rdy[0], 0);
    chk("t1_busy", bsy[0], 1);
    step();
    chk("t1_lat_o2_early", o2[0], 0);
    chk("t1_rdy_free", rdy[0], 1);
    step();
    chk("t1_msb_o2", o2[0], 1);
    chk("t1_msb_o1", o1[0], 1);
    repeat (8) step();
    chk("t1_last_o2", o2[0], 1);
    chk("t1_last_busy", bsy[0], 1);
    step();
    chk("t1_end_o2", o2[0], 0);
    chk("t1_end_busy", bsy[0], 0);
    wait_idle(0);
    chk_stream(0, "t1_stream");
    chk("t1_runs", rq[0].size(), 1);
    if (rq[0].size() == 1) chk("t1_run_len", rq[0][0], 9);

    // back-to-back frames with no gap
    clr(1);
    send(1, 8'h01);
    send(1, 8'hFF);
    wait_idle(1);
    chk_stream(1, "t2_stream");
    chk("t2_runs", rq[1].size(), 1);
    if (rq[1].size() == 1) chk("t2_run_len", rq[1][0], 18);
    if (obits[1].size() == 18) begin
      chk("t2_par1", obits[1][8], 1);
      chk("t2_par2", obits[1][17], 0);
    end

    // valid held through three words
    clr(0);
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    wait_idle(0);
    chk_stream(0, "t3_stream");
    chk("t3_runs", rq[0].size(), 3);
    chk("t3_gaps", gq[0].size(), 2);
    foreach (gq[0][k]) chk("t3_gap_len", gq[0][k], 1);

    // three-cycle gap between frames
    clr(2);
    wa = 8'($urandom);
    wb = 8'($urandom);
    send(2, wa);
    send(2, wb);
    wait_idle(2);
    chk_stream(2, "t4_stream");
    chk("t4_gaps", gq[2].size(), 1);
    if (gq[2].size() == 1) chk("t4_gap_len", gq[2][0], 3);

    // async reset mid-frame with a word waiting
    clr(0);
    wa = 8'($urandom) | 8'h08;
    wb = 8'($urandom);
    send(0, wa);
    send(0, wb);
    repeat (4) step();
    chk("t5_pre_o2", o2[0], 1);
    chk("t5_pre_o1", o1[0], 1);
    chk("t5_pre_rdy", rdy[0], 0);
    #1 reset = 1'b0;
    #1;
    chk("t5_o1", o1[0], 0);
    chk("t5_o2", o2[0], 0);
    chk("t5_rdy", rdy[0], 1);
    chk("t5_busy", bsy[0], 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();
    clr(0);
    repeat (30) step();
    chk("t5_silent", obits[0].size(), 0);
    chk("t5_rdy_after", rdy[0], 1);
    chk("t5_busy_after", bsy[0], 0);

    // zero word and narrow instance
    clr(0);
    clr(3);
    send(0, 8'h00);
    send(3, 8'h03);
    wait_idle(0);
    wait_idle(3);
    chk_stream(0, "t6_stream8");
    chk_stream(3, "t6_stream2");
    if (obits[0].size() == 9) chk("t6_par8", obits[0][8], 0);
    if (obits[3].size() == 3) chk("t6_par2", obits[3][2], 0);
    chk("t6_runs8", rq[0].size(), 1);
    if (rq[0].size() == 1) chk("t6_len8", rq[0][0], 9);
    chk("t6_runs2", rq[3].size(), 1);
    if (rq[3].size() == 1) chk("t6_len2", rq[3][0], 3);

    // random traffic with random producer pauses
    clr(1);
    for (int k = 0; k < 20; k++) begin
      send(1, 8'($urandom));
      repeat ($urandom_range(0, 12)) step();
    end
    wait_idle(1);
    chk_stream(1, "t7_stream");
    sum = 0;
    foreach (rq[1][k]) sum += rq[1][k];
    chk("t7_strobe_cycles", sum, 9 * 20);

    for (int i = 0; i < 4; i++) chk("out1_quiet", viol[i], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
